// File: rtl/logic_override_ctrl.sv
// Timed override controller: after a programmable delay, switches the
// combined output from a|b to a&b for a programmable number of cycles.
// One sequence at a time; abort cancels, rst clears everything.
module logic_override_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] delay_cyc,
    input  logic [CNT_W-1:0] hold_cyc,
    input  logic             a,
    input  logic             b,
    output logic             out,
    output logic             forced,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        FORCE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [CNT_W-1:0] hold, hold_next;
    logic             forced_next, busy_next, done_next;

    // State, counters and registered flags; rst overrides everything.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            hold   <= '0;
            forced <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            hold   <= hold_next;
            forced <= forced_next;
            busy   <= busy_next;
            done   <= done_next;
        end
    end

    // Next-state and counter logic. The DELAY count is loaded with D at the
    // accepting edge, so FORCE is entered D+1 edges later; the FORCE count is
    // loaded with H-1 so the override lasts exactly H cycles.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latches).
        state_next = state;
        cnt_next   = cnt;
        hold_next  = hold;
        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_next = DELAY;
                    cnt_next   = delay_cyc;
                    hold_next  = hold_cyc;
                end
            end
            DELAY: begin
                if (abort) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == '0) begin
                    if (hold == '0) begin
                        state_next = IDLE;
                    end else begin
                        state_next = FORCE;
                        cnt_next   = hold - 1'b1;
                    end
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            FORCE: begin
                if (abort || cnt == '0) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Next values of the registered flags; done only on normal completion.
    always_comb begin
        forced_next = (state_next == FORCE);
        busy_next   = (state_next != IDLE);
        done_next   = (state != IDLE) && !abort && (state_next == IDLE);
    end

    // Zero-latency datapath result.
    assign out = forced ? (a & b) : (a | b);

endmodule

// File: tb/tb_logic_override_ctrl.sv
// Table-driven scoreboard bench for logic_override_ctrl. Each table row is
// one sequence; expected outputs per cycle come from closed-form timing
// (E0 = accepting edge, forced on E(D+1)..E(D+H), done after E(D+1+H)).
module tb_logic_override_ctrl;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] delay_cyc;
    logic [CNT_W-1:0] hold_cyc;
    logic             a;
    logic             b;
    logic             out;
    logic             forced;
    logic             busy;
    logic             done;

    logic_override_ctrl #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .delay_cyc (delay_cyc),
        .hold_cyc  (hold_cyc),
        .a         (a),
        .b         (b),
        .out       (out),
        .forced    (forced),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int d;        // delay cycles
        int h;        // hold cycles
        int abort_k;  // edge index carrying abort, -1 = none
        int rst_k;    // edge index carrying rst, -1 = none
        int sec_k;    // edge index carrying an ignored second start, -1 = none
    } scen_t;

    typedef struct packed {
        logic forced;
        logic busy;
        logic done;
        logic out;
    } exp_t;

    scen_t tbl[14];
    exp_t  sb[$];
    int    n_pass  = 0;
    int    n_total = 0;
    int    cur_s   = -1;
    int    cur_k   = 0;

    task automatic check(input string name, input logic act, input logic want);
        n_total++;
        if (act === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s scen=%0d k=%0d: got %b expected %b", name, cur_s, cur_k, act, want);
        end
    endtask

    task automatic compare_front();
        exp_t e;
        if (sb.size() == 0) begin
            n_total++;
            $display("FAIL scoreboard_empty scen=%0d k=%0d: got 0 entries expected 1", cur_s, cur_k);
        end else begin
            e = sb.pop_front();
            check("forced", forced, e.forced);
            check("busy",   busy,   e.busy);
            check("done",   done,   e.done);
            check("out",    out,    e.out);
        end
    endtask

    // Push expectation for the state after the coming edge, then sample it
    // on the following falling edge.
    task automatic cycle(input exp_t e);
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        compare_front();
    endtask

    initial begin
        exp_t e;
        int   end_k, cutoff, last;

        //          d    h   abort rst  sec
        tbl[0]  = '{2,   3,  -1,   -1,  -1};  // basic delay+hold
        tbl[1]  = '{0,   1,  -1,   -1,  -1};  // zero delay, one-cycle hold
        tbl[2]  = '{4,   0,  -1,   -1,  -1};  // zero hold: never forced
        tbl[3]  = '{1,   8,   4,   -1,  -1};  // abort mid-FORCE
        tbl[4]  = '{1,   5,  -1,   -1,   3};  // second start ignored
        tbl[5]  = '{0,  10,  -1,    3,  -1};  // rst mid-FORCE
        tbl[6]  = '{2,   3,  -1,   -1,  -1};  // normal run after rst
        tbl[7]  = '{3,   2,   0,   -1,  -1};  // start+abort in IDLE: abort wins
        tbl[8]  = '{5,   4,   3,   -1,  -1};  // abort mid-DELAY
        tbl[9]  = '{0,   0,  -1,   -1,  -1};  // D=0, H=0
        tbl[10] = '{255, 2,  -1,   -1,  -1};  // max delay
        tbl[11] = '{1, 255,  -1,   -1,  -1};  // max hold
        tbl[12] = '{2,   2,  -1,   -1,   5};  // start on the completing edge ignored
        tbl[13] = '{3,   4,  -1,    2,  -1};  // rst mid-DELAY

        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        delay_cyc = '0;
        hold_cyc  = '0;
        a         = 1'b0;
        b         = 1'b0;
        @(negedge clk);

        // Held reset: flags low, start ignored, out = a|b.
        for (int i = 0; i < 4; i++) begin
            a     = i[0];
            b     = i[1];
            start = 1'b1;
            e     = '{forced: 1'b0, busy: 1'b0, done: 1'b0, out: i[0] | i[1]};
            cycle(e);
        end
        rst   = 1'b0;
        start = 1'b0;
        e     = '{forced: 1'b0, busy: 1'b0, done: 1'b0, out: a | b};
        cycle(e);

        // Sequences run back to back: each starts on the edge right after
        // the previous done-pulse cycle (or the idle cycle after a cancel).
        for (int s = 0; s < 14; s++) begin
            cur_s  = s;
            end_k  = tbl[s].d + 1 + tbl[s].h;
            cutoff = end_k;
            if (tbl[s].abort_k >= 0 && tbl[s].abort_k < cutoff) cutoff = tbl[s].abort_k;
            if (tbl[s].rst_k   >= 0 && tbl[s].rst_k   < cutoff) cutoff = tbl[s].rst_k;
            last = (cutoff == end_k) ? end_k : cutoff + 1;
            for (int k = 0; k <= last; k++) begin
                cur_k     = k;
                a         = 1'($urandom);
                b         = 1'($urandom);
                start     = (k == 0) || (k == tbl[s].sec_k);
                if (k == 0) begin
                    delay_cyc = CNT_W'(tbl[s].d);
                    hold_cyc  = CNT_W'(tbl[s].h);
                end else if (k == tbl[s].sec_k) begin
                    delay_cyc = '0;
                    hold_cyc  = '0;
                end else begin
                    delay_cyc = CNT_W'($urandom);
                    hold_cyc  = CNT_W'($urandom);
                end
                abort     = (k == tbl[s].abort_k);
                rst       = (k == tbl[s].rst_k);
                e.busy    = (k < cutoff);
                e.forced  = (k >= tbl[s].d + 1) && (k < cutoff);
                e.done    = (k == end_k) && (cutoff == end_k);
                e.out     = e.forced ? (a & b) : (a | b);
                cycle(e);
            end
            start = 1'b0;
            abort = 1'b0;
            rst   = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
